bp_coherence_network_chunk_reassembler: RTL and testbench
=========================================================

// Module: bp_coherence_network_chunk_reassembler
// PURPOSE
//  Receive-side endpoint of the chunked coherence network channel. Accepts header-tagged
//  chunks from one channel destination port and rebuilds full coherence packets.
//  Chunks from different sources may interleave, so it keeps one reassembly slot per source.
//  Each completed packet is presented to the local consumer with its source id.
// PARAMETERS
//  packet_width_p  64  width of a reassembled packet (bits)
//  chunk_size_p    16  payload bits carried per chunk
//  num_src_p       4   number of network sources; one reassembly slot each
//  num_dst_p       4   number of network destinations; sets dst id field width
//  dst_id_p        0   this port's destination id; used only by the optional check
//  Derived: src_w = `BSG_SAFE_CLOG2(num_src_p), dst_w = `BSG_SAFE_CLOG2(num_dst_p)
//  Derived: n_chunks = ceil(packet_width_p/chunk_size_p), chunk_w = chunk_size_p+src_w+dst_w
// PORTS
//  clk_i      in   1               clock
//  reset_i    in   1               asynchronous active-high reset
//  v_i        in   1               chunk valid
//  data_i     in   chunk_w         {dst_id, src_id, payload[chunk_size_p-1:0]}, payload in LSBs
//  ready_o    out  1               chunk accept; a chunk transfers when v_i & ready_o
//  v_o        out  1               reassembled packet valid
//  data_o     out  packet_width_p  reassembled packet
//  src_id_o   out  src_w           source slot that produced data_o
//  yumi_i     in   1               consumer takes packet; legal only while v_o=1
//  error_o    out  1               sticky dst-id mismatch flag (optional feature)
// BEHAVIOUR
//  Interface: one clock (clk_i); reset_i is asynchronous and active-high.
//  Reset values: all slot counters=0, v_o=0, data_o=0, src_id_o=0, error_o=0, ready_o=1.
//  Reset clears all partial slots. Chunks accepted before reset are discarded with no output.
//  Per-slot state:
//   - cnt: 0..n_chunks-1
//   - buf: packet_width_p bits
//   - state IDLE (cnt=0) -> COLLECT (0<cnt<n_chunks)
//  Chunk k of a packet (k=0 first) is written to buf bits [k*chunk_size_p +: chunk_size_p].
//  On the last chunk, payload bits above packet_width_p are discarded.
//  Accepted chunk with cnt<n_chunks-1: write buf, cnt++.
//  Accepted chunk with cnt=n_chunks-1: write the final chunk into buf, then:
//   - load data_o <= completed packet, src_id_o <= slot
//   - set v_o=1 on the next cycle; latency is 1 cycle from last-chunk accept to v_o
//   - clear slot cnt to 0
//  n_chunks=1: every accepted chunk completes a packet.
//  ready_o = ~v_o (registered, no combinational path from yumi_i).
//  Only one packet is pending at a time, so no output arbitration is needed.
//  yumi_i while v_o=1: v_o clears next cycle and ready_o returns 1 that same cycle.
//   - Result: one bubble per packet.
//  v_o=1 with yumi_i=0: data_o/src_id_o hold stable; v_i is ignored (ready_o=0).
//  Out-of-range src_id (>= num_src_p): chunk is accepted and dropped; no slot changes.
//  Slots are independent; arbitrary interleaving across sources is legal.
//  Order within one source must be chunk 0..n_chunks-1 (network guarantees this).
//  yumi_i asserted while v_o=0 is ignored.
// CONFIGURATION
//  BP_COHERENCE_REASSEMBLY_DST_CHECK_EN defined:
//   - an accepted chunk with dst_id != dst_id_p is dropped (no slot update)
//   - error_o is set and held until reset
//  Macro undefined: dst_id is ignored, all chunks are processed, error_o tied 0.
// TESTING
//  1. src=2 sends payloads 1111,2222,3333,4444 ->
//     v_o=1 one cycle after 4th accept, data_o=64'h4444_3333_2222_1111, src_id_o=2.
//  2. Interleave src0 {A0,A1,A2,A3} with src1 {B0..B3}, B3 last ->
//     src0 packet first, src1 packet second, both exact.
//  3. Hold yumi_i=0 for 10 cycles with v_o=1 while v_i=1 ->
//     ready_o=0, no chunk consumed, data_o stable; after yumi, ready_o=1 next cycle.
//  4. src3 sends 2 chunks, assert reset_i async mid-cycle, then src3 sends 4 new chunks ->
//     only the new packet is output.
//  5. packet_width_p=40, chunk_size_p=16: 3 chunks FFFF,EEEE,ABCD ->
//     data_o=40'hCD_EEEE_FFFF, upper 8 bits of the last chunk dropped.
//  6. Macro on, dst_id_p=1, chunk with dst_id=2 ->
//     chunk dropped, error_o=1 sticky until reset; later dst_id=1 packet still reassembles.

Source files
------------

// File: rtl/bp_coherence_network_chunk_reassembler.sv
// Rebuilds coherence packets from per-source interleaved network chunks.
// Optional destination-id check: define BP_COHERENCE_REASSEMBLY_DST_CHECK_EN.
module bp_coherence_network_chunk_reassembler #(
  parameter int packet_width_p = 64,
  parameter int chunk_size_p   = 16,
  parameter int num_src_p      = 4,
  parameter int num_dst_p      = 4,
  parameter int dst_id_p       = 0,
  localparam int src_w    = (num_src_p > 1) ? $clog2(num_src_p) : 1,
  localparam int dst_w    = (num_dst_p > 1) ? $clog2(num_dst_p) : 1,
  localparam int n_chunks = (packet_width_p + chunk_size_p - 1) / chunk_size_p,
  localparam int chunk_w  = chunk_size_p + src_w + dst_w
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [chunk_w-1:0]        data_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [packet_width_p-1:0] data_o,
  output logic [src_w-1:0]          src_id_o,
  input  logic                      yumi_i,
  output logic                      error_o
);

  localparam int buf_w = n_chunks * chunk_size_p;
  localparam int cnt_w = (n_chunks > 1) ? $clog2(n_chunks) : 1;
  localparam logic [src_w:0] num_src_lp = (src_w + 1)'(num_src_p);

  typedef enum logic [0:0] {OUT_EMPTY, OUT_FULL} out_state_e;

  out_state_e state_q, state_d;

  logic [chunk_size_p-1:0] payload;
  logic [src_w-1:0]        src_id;
  logic [dst_w-1:0]        dst_id;

  logic [cnt_w-1:0] cnt_q [num_src_p];
  logic [buf_w-1:0] buf_q [num_src_p];

  logic             accept, src_ok, dst_ok, take, last;
  logic [cnt_w-1:0] cur_cnt;
  logic [buf_w-1:0] cur_buf, merged_buf;

  assign {dst_id, src_id, payload} = data_i;

  assign v_o     = (state_q == OUT_FULL);
  assign ready_o = (state_q == OUT_EMPTY);

  // Slot buffer is padded to whole chunks; the excess of the last chunk is cut at data_o.
  always_comb begin
    src_ok     = ({1'b0, src_id} < num_src_lp);
    accept     = v_i & ready_o;
    take       = accept & src_ok & dst_ok;
    cur_cnt    = '0;
    cur_buf    = '0;
    if (src_ok) begin
      cur_cnt = cnt_q[src_id];
      cur_buf = buf_q[src_id];
    end
    last       = (cur_cnt == cnt_w'(n_chunks - 1));
    merged_buf = cur_buf;
    merged_buf[cur_cnt*chunk_size_p +: chunk_size_p] = payload;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < num_src_p; i++) begin
        cnt_q[i] <= '0;
        buf_q[i] <= '0;
      end
    end else if (take) begin
      cnt_q[src_id] <= last ? '0 : cur_cnt + cnt_w'(1);
      buf_q[src_id] <= merged_buf;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_o   <= '0;
      src_id_o <= '0;
    end else if (take && last) begin
      data_o   <= merged_buf[packet_width_p-1:0];
      src_id_o <= src_id;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= OUT_EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (take && last) state_d = OUT_FULL;
      OUT_FULL:  if (yumi_i)       state_d = OUT_EMPTY;
      default:                     state_d = OUT_EMPTY;
    endcase
  end

`ifdef BP_COHERENCE_REASSEMBLY_DST_CHECK_EN
  logic error_q;

  assign dst_ok  = (dst_id == dst_w'(dst_id_p));
  assign error_o = error_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)               error_q <= 1'b0;
    else if (accept && !dst_ok) error_q <= 1'b1;
  end
`else
  logic unused_dst;

  assign dst_ok     = 1'b1;
  assign error_o    = 1'b0;
  assign unused_dst = ^{dst_id, dst_w'(dst_id_p)};
`endif

endmodule

// File: tb/tb_bp_coherence_network_chunk_reassembler.sv
// Directed bench: vector table for streaming/interleave, hand sequences for stall, reset, width and dst cases.
module tb_bp_coherence_network_chunk_reassembler;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;

  logic        v_i = 1'b0, yumi_i = 1'b0;
  logic [19:0] data_i = '0;
  logic        ready_o, v_o, error_o;
  logic [63:0] data_o;
  logic [1:0]  src_id_o;

  logic        v40 = 1'b0, yumi40 = 1'b0;
  logic [19:0] d40 = '0;
  logic        ready40, vo40, err40;
  logic [39:0] do40;
  logic [1:0]  src40;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bp_coherence_network_chunk_reassembler #(
    .packet_width_p(64), .chunk_size_p(16), .num_src_p(4), .num_dst_p(4), .dst_id_p(1)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .src_id_o(src_id_o), .yumi_i(yumi_i), .error_o(error_o)
  );

  bp_coherence_network_chunk_reassembler #(
    .packet_width_p(40), .chunk_size_p(16), .num_src_p(3), .num_dst_p(4), .dst_id_p(0)
  ) dut40 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v40), .data_i(d40), .ready_o(ready40),
    .v_o(vo40), .data_o(do40), .src_id_o(src40), .yumi_i(yumi40), .error_o(err40)
  );

  typedef struct {
    logic        v;
    logic [1:0]  src;
    logic [1:0]  dst;
    logic [15:0] pay;
    logic        yumi;
    logic        ev;
    logic        er;
    logic [63:0] ed;
    logic [1:0]  es;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] src, input logic [1:0] dst,
                      input logic [15:0] pay, input logic yumi);
    @(negedge clk);
    v_i    = v;
    data_i = {dst, src, pay};
    yumi_i = yumi;
    @(posedge clk);
    #1;
  endtask

  task automatic step40(input logic v, input logic [1:0] src, input logic [15:0] pay,
                        input logic yumi);
    @(negedge clk);
    v40    = v;
    d40    = {2'd0, src, pay};
    yumi40 = yumi;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic ev, input logic er,
                          input logic [63:0] ed, input logic [1:0] es);
    chk({tag, " v_o"}, {63'd0, v_o}, {63'd0, ev});
    chk({tag, " ready_o"}, {63'd0, ready_o}, {63'd0, er});
    chk({tag, " data_o"}, data_o, ed);
    chk({tag, " src_id_o"}, {62'd0, src_id_o}, {62'd0, es});
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] src, input logic [15:0] pay,
                              input logic yumi, input logic ev, input logic [63:0] ed,
                              input logic [1:0] es);
    vec_t r;
    r.v = v; r.src = src; r.dst = 2'd1; r.pay = pay; r.yumi = yumi;
    r.ev = ev; r.er = ~ev; r.ed = ed; r.es = es;
    return r;
  endfunction

  initial begin
    logic [63:0] pa, pb, p1;
    pa = 64'h4444_3333_2222_1111;
    pb = 64'hA003_A002_A001_A000;
    p1 = 64'hB003_B002_B001_B000;

    tbl[0]  = mk(1, 2'd2, 16'h1111, 0, 0, 64'd0, 2'd0);
    tbl[1]  = mk(1, 2'd2, 16'h2222, 0, 0, 64'd0, 2'd0);
    tbl[2]  = mk(1, 2'd2, 16'h3333, 0, 0, 64'd0, 2'd0);
    tbl[3]  = mk(1, 2'd2, 16'h4444, 0, 1, pa, 2'd2);
    tbl[4]  = mk(0, 2'd0, 16'h0000, 1, 0, pa, 2'd2);
    tbl[5]  = mk(0, 2'd0, 16'h0000, 1, 0, pa, 2'd2);
    tbl[6]  = mk(1, 2'd0, 16'hA000, 0, 0, pa, 2'd2);
    tbl[7]  = mk(1, 2'd1, 16'hB000, 0, 0, pa, 2'd2);
    tbl[8]  = mk(1, 2'd0, 16'hA001, 0, 0, pa, 2'd2);
    tbl[9]  = mk(1, 2'd1, 16'hB001, 0, 0, pa, 2'd2);
    tbl[10] = mk(1, 2'd0, 16'hA002, 0, 0, pa, 2'd2);
    tbl[11] = mk(1, 2'd1, 16'hB002, 0, 0, pa, 2'd2);
    tbl[12] = mk(1, 2'd0, 16'hA003, 0, 1, pb, 2'd0);
    tbl[13] = mk(0, 2'd0, 16'h0000, 1, 0, pb, 2'd0);
    tbl[14] = mk(1, 2'd1, 16'hB003, 0, 1, p1, 2'd1);
    tbl[15] = mk(0, 2'd0, 16'h0000, 1, 0, p1, 2'd1);

    #1;
    chk_main("reset", 1'b0, 1'b1, 64'd0, 2'd0);
    chk("reset error_o", {63'd0, error_o}, 64'd0);
    @(negedge clk);
    reset_i = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].src, tbl[i].dst, tbl[i].pay, tbl[i].yumi);
      chk_main($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].er, tbl[i].ed, tbl[i].es);
      chk($sformatf("tbl[%0d] error_o", i), {63'd0, error_o}, 64'd0);
    end

    // Backpressure: v_i held high while packet waits must not be consumed.
    step(1, 2'd1, 2'd1, 16'h0011, 0);
    step(1, 2'd1, 2'd1, 16'h0022, 0);
    step(1, 2'd1, 2'd1, 16'h0033, 0);
    step(1, 2'd1, 2'd1, 16'h0044, 0);
    chk_main("stall fill", 1'b1, 1'b0, 64'h0044_0033_0022_0011, 2'd1);
    for (int i = 0; i < 10; i++) begin
      step(1, 2'd1, 2'd1, 16'h9999, 0);
      chk_main($sformatf("stall[%0d]", i), 1'b1, 1'b0, 64'h0044_0033_0022_0011, 2'd1);
    end
    step(0, 2'd1, 2'd1, 16'h0000, 1);
    chk_main("stall yumi", 1'b0, 1'b1, 64'h0044_0033_0022_0011, 2'd1);
    step(1, 2'd1, 2'd1, 16'h0005, 0);
    step(1, 2'd1, 2'd1, 16'h0006, 0);
    step(1, 2'd1, 2'd1, 16'h0007, 0);
    chk("stall no early v_o", {63'd0, v_o}, 64'd0);
    step(1, 2'd1, 2'd1, 16'h0008, 0);
    chk_main("stall next pkt", 1'b1, 1'b0, 64'h0008_0007_0006_0005, 2'd1);
    step(0, 2'd0, 2'd1, 16'h0000, 1);

    // Asynchronous reset mid-cycle discards a partial src3 packet.
    step(1, 2'd3, 2'd1, 16'hDEAD, 0);
    step(1, 2'd3, 2'd1, 16'hBEEF, 0);
    v_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    chk_main("async reset", 1'b0, 1'b1, 64'd0, 2'd0);
    @(negedge clk);
    reset_i = 1'b0;
    step(1, 2'd3, 2'd1, 16'h0001, 0);
    step(1, 2'd3, 2'd1, 16'h0002, 0);
    chk("post-reset no early v_o", {63'd0, v_o}, 64'd0);
    step(1, 2'd3, 2'd1, 16'h0003, 0);
    chk("post-reset no early v_o 3", {63'd0, v_o}, 64'd0);
    step(1, 2'd3, 2'd1, 16'h0004, 0);
    chk_main("post-reset pkt", 1'b1, 1'b0, 64'h0004_0003_0002_0001, 2'd3);
    step(0, 2'd0, 2'd1, 16'h0000, 1);

    // 40-bit packets: 3 chunks, top byte of the last chunk dropped; src3 is out of range.
    step40(1, 2'd0, 16'hFFFF, 0);
    step40(1, 2'd3, 16'h1234, 0);
    chk("w40 oor no v_o", {63'd0, vo40}, 64'd0);
    chk("w40 oor ready", {63'd0, ready40}, 64'd1);
    step40(1, 2'd0, 16'hEEEE, 0);
    chk("w40 no early v_o", {63'd0, vo40}, 64'd0);
    step40(1, 2'd0, 16'hABCD, 0);
    chk("w40 v_o", {63'd0, vo40}, 64'd1);
    chk("w40 data_o", {24'd0, do40}, 64'h00_0000_00CD_EEEE_FFFF);
    chk("w40 src_id_o", {62'd0, src40}, 64'd0);
    step40(0, 2'd0, 16'h0000, 1);
    chk("w40 after yumi", {63'd0, vo40}, 64'd0);
    chk("w40 error_o", {63'd0, err40}, 64'd0);

`ifdef BP_COHERENCE_REASSEMBLY_DST_CHECK_EN
    step(1, 2'd0, 2'd2, 16'h7777, 0);
    chk("dst drop error_o", {63'd0, error_o}, 64'd1);
    chk("dst drop v_o", {63'd0, v_o}, 64'd0);
    step(1, 2'd0, 2'd1, 16'h0001, 0);
    step(1, 2'd0, 2'd1, 16'h0002, 0);
    step(1, 2'd0, 2'd1, 16'h0003, 0);
    chk("dst no early v_o", {63'd0, v_o}, 64'd0);
    step(1, 2'd0, 2'd1, 16'h0004, 0);
    chk_main("dst pkt", 1'b1, 1'b0, 64'h0004_0003_0002_0001, 2'd0);
    chk("dst error sticky", {63'd0, error_o}, 64'd1);
    step(0, 2'd0, 2'd1, 16'h0000, 1);
    chk("dst error held", {63'd0, error_o}, 64'd1);
    reset_i = 1'b1;
    #1;
    chk("dst error reset", {63'd0, error_o}, 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
`else
    step(1, 2'd0, 2'd2, 16'h7777, 0);
    step(1, 2'd0, 2'd3, 16'h0001, 0);
    step(1, 2'd0, 2'd0, 16'h0002, 0);
    step(1, 2'd0, 2'd2, 16'h0003, 0);
    chk_main("dst ignored pkt", 1'b1, 1'b0, 64'h0003_0002_0001_7777, 2'd0);
    chk("dst ignored error_o", {63'd0, error_o}, 64'd0);
    step(0, 2'd0, 2'd1, 16'h0000, 1);
    chk("dst ignored after yumi", {63'd0, v_o}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
